fir_output_checker: RTL and testbench

- Synthesizable sink-side checker for the fir_filter output stream. It is the hardware counterpart of the stimulus side: the source drives x, and this block consumes y.
- Skips the pipeline-fill window, then compares each output sample against an expected value from an on-block FIFO, using an absolute tolerance.
- Counts matches and mismatches, latches the first mismatch index, and computes the integer match-rate percentage.
- Sits beside fir_filter in FPGA self-test builds; expected values are loaded by a host or BRAM reader.

---
 rtl/fir_chk_pkg.sv | 29 ++
 rtl/chk_sync_fifo.sv | 55 +++++
 rtl/fir_output_checker.sv | 223 ++++++++++++++++++++++
 tb/tb_fir_output_checker.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_chk_pkg.sv
// Shared types and helpers for the fir_filter output checker.
// Holds the FSM state type, the rate width and the |a-b| helper.
package fir_chk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        COMPARE,
        RATE,
        DONE
    } state_t;

    localparam int RATE_W = 7;

    // Callers sign-extend their samples to this width, so one helper
    // serves any DATA_WIDTH up to ABS_IN_W.
    localparam int ABS_IN_W = 32;

    // One extra bit keeps the difference of two extreme values exact.
    function automatic logic [ABS_IN_W:0] abs_diff(
        input logic signed [ABS_IN_W-1:0] a,
        input logic signed [ABS_IN_W-1:0] b
    );
        logic signed [ABS_IN_W:0] d;
        d = {a[ABS_IN_W-1], a} - {b[ABS_IN_W-1], b};
        return d[ABS_IN_W] ? $unsigned(-d) : $unsigned(d);
    endfunction

endpackage

// File: rtl/chk_sync_fifo.sv
// First-word-fall-through synchronous FIFO for expected samples.
// The caller guarantees push only when not full or popping.
module chk_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;

    // Next pointer and occupancy values.
    always_comb begin
        wr_d  = wr_q + AW'(push);
        rd_d  = rd_q + AW'(pop);
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    // Pointer and occupancy registers, emptied by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_q];
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/fir_output_checker.sv
// Sink-side checker for the fir_filter output stream: skips the fill
// window, compares y to queued expected values, and reports a match rate.
module fir_output_checker
    import fir_chk_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DELAY      = 9,
    parameter int TOLERANCE  = 4,
    parameter int SAMPLE_NUM = 5000,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] y,
    input  logic                         exp_valid,
    input  logic signed [DATA_WIDTH-1:0] exp_data,
    output logic                         exp_ready,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_WIDTH-1:0]         match_cnt,
    output logic [CNT_WIDTH-1:0]         mismatch_cnt,
    output logic [CNT_WIDTH-1:0]         first_mm_idx,
    output logic [RATE_W-1:0]            match_rate,
    output logic                         underrun
);

    localparam int DVD_W = CNT_WIDTH + RATE_W;
    localparam int BC_W  = $clog2(DVD_W);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   skip_q, skip_d;
    logic [CNT_WIDTH-1:0]   idx_q, idx_d;
    logic                   cmp_vld_q, cmp_vld_d;
    logic                   cmp_match_q, cmp_match_d;
    logic [CNT_WIDTH-1:0]   cmp_idx_q, cmp_idx_d;
    logic [CNT_WIDTH-1:0]   match_q, match_d;
    logic [CNT_WIDTH-1:0]   mm_q, mm_d;
    logic [CNT_WIDTH-1:0]   first_q, first_d;
    logic [RATE_W-1:0]      rate_q, rate_d;
    logic                   under_q, under_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [DVD_W-1:0]       dvd_q, dvd_d;
    logic [CNT_WIDTH-1:0]   rem_q, rem_d;
    logic [BC_W-1:0]        bit_q, bit_d;

    logic                   pop;
    logic                   push;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic signed [DATA_WIDTH-1:0] fifo_dout;
    logic [ABS_IN_W:0]      mag;
    logic [CNT_WIDTH:0]     rem_sh;
    logic [CNT_WIDTH:0]     rem_nx;
    logic                   q_bit;
    logic [DVD_W-1:0]       dvd_nx;

    // Pop is a pure function of state, so exp_ready never sees exp_valid.
    assign exp_ready = !fifo_full || pop;
    assign push      = exp_valid && exp_ready && !reset;

    chk_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (exp_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign mag = abs_diff(ABS_IN_W'(y), ABS_IN_W'(fifo_dout));

    // One restoring-divide step: quotient bits shift into dvd from the right.
    always_comb begin
        rem_sh = {rem_q, dvd_q[DVD_W-1]};
        q_bit  = (rem_sh >= (CNT_WIDTH+1)'(SAMPLE_NUM));
        rem_nx = q_bit ? rem_sh - (CNT_WIDTH+1)'(SAMPLE_NUM) : rem_sh;
        dvd_nx = {dvd_q[DVD_W-2:0], q_bit};
    end

    // Next-state, compare, counter and divider logic.
    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        idx_d       = idx_q;
        cmp_vld_d   = 1'b0;
        cmp_match_d = cmp_match_q;
        cmp_idx_d   = cmp_idx_q;
        match_d     = match_q;
        mm_d        = mm_q;
        first_d     = first_q;
        rate_d      = rate_q;
        under_d     = under_q;
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        bit_d       = bit_q;
        pop         = 1'b0;

        // Counters trail the sample by one cycle.
        if (cmp_vld_q) begin
            if (cmp_match_q) begin
                match_d = match_q + CNT_WIDTH'(1);
            end else begin
                mm_d = mm_q + CNT_WIDTH'(1);
                if (first_q == '1) begin
                    first_d = cmp_idx_q;
                end
            end
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SKIP;
                    skip_d  = '0;
                    match_d = '0;
                    mm_d    = '0;
                    first_d = '1;
                    rate_d  = '0;
                    under_d = 1'b0;
                end
            end
            SKIP: begin
                if (skip_q == CNT_WIDTH'(DELAY)) begin
                    state_d = COMPARE;
                    idx_d   = '0;
                end else begin
                    skip_d = skip_q + CNT_WIDTH'(1);
                end
            end
            COMPARE: begin
                if (idx_q == CNT_WIDTH'(SAMPLE_NUM)) begin
                    // Extra cycle lets the last result land in the counters.
                    state_d = RATE;
                    dvd_d   = DVD_W'(match_d) * DVD_W'(100);
                    rem_d   = '0;
                    bit_d   = '0;
                end else begin
                    cmp_vld_d   = 1'b1;
                    cmp_idx_d   = idx_q;
                    cmp_match_d = !fifo_empty &&
                                  (mag <= (ABS_IN_W+1)'(TOLERANCE));
                    pop         = !fifo_empty;
                    if (fifo_empty) begin
                        under_d = 1'b1;
                    end
                    idx_d = idx_q + CNT_WIDTH'(1);
                end
            end
            RATE: begin
                dvd_d = dvd_nx;
                rem_d = CNT_WIDTH'(rem_nx);
                bit_d = bit_q + BC_W'(1);
                if (bit_q == BC_W'(DVD_W - 1)) begin
                    state_d = DONE;
                    rate_d  = RATE_W'(dvd_nx);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SKIP) || (state_d == COMPARE) ||
                 (state_d == RATE);
        done_d = (state_d == DONE);
    end

    // Single register bank for the FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            skip_q      <= '0;
            idx_q       <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_match_q <= 1'b0;
            cmp_idx_q   <= '0;
            match_q     <= '0;
            mm_q        <= '0;
            first_q     <= '1;
            rate_q      <= '0;
            under_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dvd_q       <= '0;
            rem_q       <= '0;
            bit_q       <= '0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            idx_q       <= idx_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_match_q <= cmp_match_d;
            cmp_idx_q   <= cmp_idx_d;
            match_q     <= match_d;
            mm_q        <= mm_d;
            first_q     <= first_d;
            rate_q      <= rate_d;
            under_q     <= under_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dvd_q       <= dvd_d;
            rem_q       <= rem_d;
            bit_q       <= bit_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign match_cnt    = match_q;
    assign mismatch_cnt = mm_q;
    assign first_mm_idx = first_q;
    assign match_rate   = rate_q;
    assign underrun     = under_q;

endmodule

// File: tb/tb_fir_output_checker.sv
// Directed self-checking bench for fir_output_checker.
// SAMPLE_NUM=8, DELAY=2, TOLERANCE=4, hand-computed expectations.
module tb_fir_output_checker;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic signed [15:0] y;
    logic               exp_valid;
    logic signed [15:0] exp_data;
    logic               exp_ready;
    logic               busy;
    logic               done;
    logic [15:0]        match_cnt;
    logic [15:0]        mismatch_cnt;
    logic [15:0]        first_mm_idx;
    logic [6:0]         match_rate;
    logic               underrun;

    int n_assert = 0;
    int n_fail   = 0;

    logic signed [15:0] ev [16];
    logic signed [15:0] yv [8];

    always #5 clk = ~clk;

    fir_output_checker #(
        .DATA_WIDTH (16),
        .DELAY      (2),
        .TOLERANCE  (4),
        .SAMPLE_NUM (8),
        .FIFO_DEPTH (16),
        .CNT_WIDTH  (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .y            (y),
        .exp_valid    (exp_valid),
        .exp_data     (exp_data),
        .exp_ready    (exp_ready),
        .busy         (busy),
        .done         (done),
        .match_cnt    (match_cnt),
        .mismatch_cnt (mismatch_cnt),
        .first_mm_idx (first_mm_idx),
        .match_rate   (match_rate),
        .underrun     (underrun)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input int m, input int mm,
                           input int first, input int rate, input bit und);
        check({tag, ".match"}, 32'(match_cnt), 32'(m));
        check({tag, ".mism"}, 32'(mismatch_cnt), 32'(mm));
        check({tag, ".first"}, 32'(first_mm_idx), 32'(first));
        check({tag, ".rate"}, 32'(match_rate), 32'(rate));
        check({tag, ".under"}, 32'(underrun), 32'(und));
    endtask

    task automatic chk_reset(input string tag);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".done"}, 32'(done), 0);
        check({tag, ".rdy"}, 32'(exp_ready), 1);
        chk_res(tag, 0, 0, 32'hFFFF, 0, 1'b0);
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_valid = 1'b1;
            exp_data  = ev[i];
        end
        @(negedge clk);
        exp_valid = 1'b0;
    endtask

    // start, three fill cycles, eight samples, then wait out the divider.
    task automatic run(input string tag, input bit s_skip,
                       input bit s_rate, input bit push_on);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        y     = 16'sh5A5A;
        @(negedge clk);
        y     = -16'sh25A5;
        start = s_skip;
        @(negedge clk);
        y     = 16'sh7E7E;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            y = yv[i];
            if (push_on) begin
                exp_valid = 1'b1;
                exp_data  = 16'(16 + i);
                check({tag, ".rdy_cmp"}, 32'(exp_ready), 1);
            end
        end
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            exp_valid = 1'b0;
            start     = s_rate && (k == 6);
        end
        check({tag, ".done_early"}, 32'(done), 0);
        check({tag, ".busy_rate"}, 32'(busy), 1);
        @(negedge clk);
        check({tag, ".done"}, 32'(done), 1);
        check({tag, ".busy_done"}, 32'(busy), 0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        y         = '0;
        exp_valid = 1'b0;
        exp_data  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_reset("rst");

        // All exact.
        for (int i = 0; i < 8; i++) begin
            ev[i] = 16'(i);
            yv[i] = 16'(i);
        end
        load(8);
        run("exact", 1'b0, 1'b0, 1'b0);
        chk_res("exact", 8, 0, 32'hFFFF, 100, 1'b0);

        // +4 passes at idx2, -5 fails at idx5.
        load(8);
        yv[2] = 16'sd6;
        yv[5] = 16'sd0;
        run("tol", 1'b0, 1'b0, 1'b0);
        chk_res("tol", 7, 1, 5, 87, 1'b0);

        // Extremes: -32768 vs 32767 must not wrap into a match.
        for (int i = 0; i < 8; i++) begin
            yv[i] = 16'(i);
        end
        ev[0] = -16'sd32768;
        ev[1] = 16'sd32767;
        yv[0] = 16'sd32767;
        yv[1] = 16'sd32765;
        load(8);
        run("ext", 1'b0, 1'b0, 1'b0);
        chk_res("ext", 7, 1, 0, 87, 1'b0);

        // Only six expected values queued.
        for (int i = 0; i < 8; i++) begin
            ev[i] = 16'(i);
            yv[i] = 16'(i);
        end
        load(6);
        run("under", 1'b0, 1'b0, 1'b0);
        chk_res("under", 6, 2, 6, 75, 1'b1);

        // Full FIFO with writes held during compare.
        for (int i = 0; i < 16; i++) begin
            ev[i] = 16'(i);
        end
        load(16);
        check("full.rdy", 32'(exp_ready), 0);
        run("full", 1'b0, 1'b0, 1'b1);
        chk_res("full", 8, 0, 32'hFFFF, 100, 1'b0);
        check("full.rdy_after", 32'(exp_ready), 0);
        for (int i = 0; i < 8; i++) begin
            yv[i] = 16'(8 + i);
        end
        run("drainA", 1'b0, 1'b0, 1'b0);
        chk_res("drainA", 8, 0, 32'hFFFF, 100, 1'b0);
        check("drainA.rdy", 32'(exp_ready), 1);
        for (int i = 0; i < 8; i++) begin
            yv[i] = 16'(16 + i);
        end
        run("drainB", 1'b0, 1'b0, 1'b0);
        chk_res("drainB", 8, 0, 32'hFFFF, 100, 1'b0);

        // Abort at compare idx4 with reset.
        for (int i = 0; i < 8; i++) begin
            yv[i] = 16'(i);
        end
        load(8);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        y     = 16'sh1111;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            y = yv[i];
        end
        @(negedge clk);
        y     = yv[4];
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset("abort");

        // Fresh run; stray starts in SKIP and RATE are ignored.
        load(8);
        run("restart", 1'b1, 1'b1, 1'b0);
        chk_res("restart", 8, 0, 32'hFFFF, 100, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
